// File: rtl/prog_loader_if.sv
// Loader byte stream (valid/ready) plus the core's instruction-fetch and status signals.
// The master drives bytes and fetch addresses; the slave is the loader/instruction memory.
interface prog_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [31:0] instr_addr;
    logic [31:0] instr_data;
    logic [31:0] last_pc;
    logic        loaded;
    logic        err;

    modport master (
        output in_valid, in_data, instr_addr,
        input  in_ready, instr_data, last_pc, loaded, err
    );

    modport slave (
        input  in_valid, in_data, instr_addr,
        output in_ready, instr_data, last_pc, loaded, err
    );
endinterface

// File: rtl/prog_loader.sv
// Loads a count-prefixed little-endian byte stream into instruction memory; reads are combinational.
// One byte per cycle; in_ready drops for good once the load finishes or the header is rejected.
module prog_loader #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic         clk,
    input  logic         rst,
    prog_loader_if.slave bus
);
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    typedef enum logic [2:0] {CNT_LO, CNT_HI, DATA, DONE, ERR} state_t;

    state_t         state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [AW-1:0]  widx_q, widx_d;
    logic [1:0]     lane_q, lane_d;
    logic [23:0]    asm_q, asm_d;
    logic           mem_we;
    logic [31:0]    mem_wdat;
    logic [15:0]    cnt_full;
    logic [15:0]    widx_ext;
    logic           accept;
    logic           loaded;

    logic [31:0]    mem [DEPTH];

    assign cnt_full      = {bus.in_data, cnt_q[7:0]};
    assign widx_ext      = {{(16-AW){1'b0}}, widx_q};
    assign loaded        = (state_q == DONE);
    assign bus.in_ready  = (state_q == CNT_LO) || (state_q == CNT_HI) || (state_q == DATA);
    assign bus.loaded    = loaded;
    assign bus.err       = (state_q == ERR);
    assign accept        = bus.in_valid && bus.in_ready;

    // Masking by loaded and N keeps stale words from a previous program invisible.
    assign bus.instr_data = (loaded && (bus.instr_addr < {16'h0, cnt_q}))
                            ? mem[bus.instr_addr[AW-1:0]] : NOP;
    assign bus.last_pc    = loaded ? {16'h0, cnt_q - 16'd1} : 32'hFFFF_FFFF;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        widx_d   = widx_q;
        lane_d   = lane_q;
        asm_d    = asm_q;
        mem_we   = 1'b0;
        mem_wdat = {bus.in_data, asm_q};
        case (state_q)
            CNT_LO: begin
                if (accept) begin
                    cnt_d[7:0] = bus.in_data;
                    state_d    = CNT_HI;
                end
            end
            CNT_HI: begin
                if (accept) begin
                    cnt_d[15:8] = bus.in_data;
                    if ((cnt_full == 16'd0) || ({1'b0, cnt_full} > DEPTH_L)) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                        widx_d  = '0;
                        lane_d  = '0;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0: asm_d[7:0]   = bus.in_data;
                        2'd1: asm_d[15:8]  = bus.in_data;
                        2'd2: asm_d[23:16] = bus.in_data;
                        default: begin
                            mem_we = 1'b1;
                            widx_d = widx_q + AW'(1);
                            if (widx_ext == (cnt_q - 16'd1)) begin
                                state_d = DONE;
                            end
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CNT_LO;
            cnt_q   <= '0;
            widx_q  <= '0;
            lane_q  <= '0;
            asm_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
            lane_q  <= lane_d;
            asm_q   <= asm_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[widx_q] <= mem_wdat;
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: a byte-list reference model predicts every fetch/status probe.
module tb_prog_loader;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prog_loader_if ifc();

    prog_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] last_pc;
        logic        loaded;
        logic        err;
        logic        rdy;
    } exp_t;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  bytes_q[$];
    exp_t        sb_q[$];
    exp_t        mon_e;
    logic        chk_vld  = 1'b0;

    // Reference model: everything derives from the list of bytes accepted since reset.
    function automatic int unsigned m_n();
        if (bytes_q.size() < 2) return 0;
        return 32'({bytes_q[1], bytes_q[0]});
    endfunction

    function automatic bit m_err();
        return (bytes_q.size() >= 2) && ((m_n() == 0) || (m_n() > DEPTH));
    endfunction

    function automatic bit m_loaded();
        return (bytes_q.size() >= 2) && !m_err() && (bytes_q.size() >= 2 + 4 * m_n());
    endfunction

    function automatic bit m_ready();
        return !m_err() && !m_loaded();
    endfunction

    function automatic logic [31:0] m_data(input logic [31:0] addr);
        int unsigned b;
        if (m_loaded() && (addr < m_n())) begin
            b = 2 + 4 * addr;
            return {bytes_q[b+3], bytes_q[b+2], bytes_q[b+1], bytes_q[b]};
        end
        return 32'h0000_0013;
    endfunction

    task automatic cmp(input string name, input logic [31:0] addr,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s addr=%h: got %h expected %h", name, addr, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_vld) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: got empty queue expected an entry");
            end else begin
                mon_e = sb_q.pop_front();
                cmp("instr_data", mon_e.addr, ifc.instr_data, mon_e.data);
                cmp("last_pc",    mon_e.addr, ifc.last_pc,    mon_e.last_pc);
                cmp("loaded",     mon_e.addr, 32'(ifc.loaded),   32'(mon_e.loaded));
                cmp("err",        mon_e.addr, 32'(ifc.err),      32'(mon_e.err));
                cmp("in_ready",   mon_e.addr, 32'(ifc.in_ready), 32'(mon_e.rdy));
            end
        end
    end

    task automatic probe(input logic [31:0] addr);
        exp_t e;
        ifc.instr_addr = addr;
        e.addr    = addr;
        e.data    = m_data(addr);
        e.last_pc = m_loaded() ? (m_n() - 1) : 32'hFFFF_FFFF;
        e.loaded  = m_loaded();
        e.err     = m_err();
        e.rdy     = m_ready();
        sb_q.push_back(e);
        chk_vld = 1'b1;
        @(negedge clk);
        #1 chk_vld = 1'b0;
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, m_n() + 1));
            1:       return 32'hFFFF_FFFF;
            2:       return $urandom;
            default: return 32'($urandom_range(0, DEPTH - 1));
        endcase
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit pre;
        if (gap) begin
            @(posedge clk);
            #1;
        end
        ifc.in_valid = 1'b1;
        ifc.in_data  = b;
        pre = m_ready();
        @(posedge clk);
        if (pre) bytes_q.push_back(b);
        #1;
        ifc.in_valid = 1'b0;
        ifc.in_data  = 8'($urandom);
    endtask

    // gapmode: 0 = back-to-back, 1 = idle cycle before every byte, 2 = random idles.
    task automatic send_stream(input logic [7:0] s[$], input int gapmode);
        bit gap;
        for (int i = 0; i < s.size(); i++) begin
            gap = (gapmode == 1) || ((gapmode == 2) && ($urandom_range(0, 1) == 1));
            send_byte(s[i], gap);
            probe(pick_addr());
        end
    endtask

    task automatic do_reset(input bit with_byte);
        rst          = 1'b1;
        ifc.in_valid = with_byte;
        ifc.in_data  = 8'hAA;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        ifc.in_valid = 1'b0;
        bytes_q.delete();
    endtask

    logic [7:0] nom [10] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                             8'h13, 8'h01, 8'h20, 8'h00};
    logic [7:0] s[$];
    int         n;

    initial begin
        rst            = 1'b1;
        ifc.in_valid   = 1'b0;
        ifc.in_data    = 8'h00;
        ifc.instr_addr = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        do_reset(1'b0);

        // Reset state and pre-load reads.
        probe(32'h0);
        probe(32'h5);
        probe(32'hFFFF_FFFF);

        // Nominal load, then the same stream with gaps.
        for (int g = 0; g < 2; g++) begin
            do_reset(1'b0);
            s.delete();
            for (int i = 0; i < 10; i++) s.push_back(nom[i]);
            send_stream(s, g);
            probe(32'h0);
            probe(32'h1);
            probe(32'h2);
        end

        // Header errors: zero count, DEPTH+1, with trailing bytes ignored.
        do_reset(1'b0);
        s.delete();
        s.push_back(8'h00); s.push_back(8'h00);
        for (int i = 0; i < 4; i++) s.push_back(8'(i + 1));
        send_stream(s, 0);
        probe(32'h0);

        do_reset(1'b0);
        s.delete();
        s.push_back(8'((DEPTH + 1) & 255)); s.push_back(8'((DEPTH + 1) >> 8));
        for (int i = 0; i < 4; i++) s.push_back(8'($urandom));
        send_stream(s, 0);
        probe(32'h0);

        // Full-depth load, word i = i.
        do_reset(1'b0);
        s.delete();
        s.push_back(8'(DEPTH & 255)); s.push_back(8'(DEPTH >> 8));
        for (int i = 0; i < DEPTH; i++) begin
            s.push_back(8'(i)); s.push_back(8'(i >> 8));
            s.push_back(8'h00); s.push_back(8'h00);
        end
        send_stream(s, 0);
        probe(32'(DEPTH - 1));
        probe(32'(DEPTH));
        probe(32'h0);
        probe(32'd100);

        // Reset mid-load; the byte presented during reset must be dropped.
        do_reset(1'b0);
        s.delete();
        s.push_back(8'h02); s.push_back(8'h00);
        for (int i = 0; i < 5; i++) s.push_back(8'($urandom));
        send_stream(s, 0);
        do_reset(1'b1);
        s.delete();
        s.push_back(8'h01); s.push_back(8'h00);
        s.push_back(8'h33); s.push_back(8'h05); s.push_back(8'h00); s.push_back(8'h00);
        send_stream(s, 0);
        probe(32'h0);
        probe(32'h1);

        // Random programs with random gaps, occasionally with a bad count.
        for (int t = 0; t < 8; t++) begin
            do_reset(1'b0);
            s.delete();
            n = (t == 7) ? DEPTH + 1 + $urandom_range(0, 300) : $urandom_range(1, 12);
            s.push_back(8'(n & 255)); s.push_back(8'(n >> 8));
            for (int i = 0; i < 4 * ((n > DEPTH) ? 2 : n); i++) s.push_back(8'($urandom));
            send_stream(s, 2);
            probe(32'(n - 1));
            probe(32'(n));
            probe(32'h0);
        end

        repeat (2) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
# prog_loader

Instruction-side upstream stage of the CPU core. Accepts a program as a byte stream over a valid/ready handshake and writes it into a word-addressed instruction memory. Serves the core's instruction-fetch port (`instr_addr` → `instr_data`) and drives the core's `last_pc` input. Until a load completes, the core is held at its reset PC (`last_pc` = 0xFFFFFFFF).

## Interface
Parameters:
- `DEPTH`, 256: instruction memory size in 32-bit words; power of two, at most 65535.
- `AW`, 8: word index width, equal to log2(`DEPTH`).

Ports:
- `clk`  in  1: the only clock; all state changes on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: a loader byte is present on `in_data`.
- `in_data`  in  8: loader byte.
- `in_ready`  out  1: the block accepts a byte this cycle.
- `instr_addr`  in  32: word index requested by the core.
- `instr_data`  out  32: instruction at `instr_addr` (combinational).
- `last_pc`  out  32: index of the last valid instruction.
- `loaded`  out  1: program load finished successfully.
- `err`  out  1: malformed header; sticky until `rst`.

## Operation
- Byte transfer: a byte is consumed on a rising edge where `in_valid && in_ready`. No other condition consumes a byte.
- Stream format:
  - 2-byte little-endian word count N.
  - Then N×4 bytes, each word little-endian (first byte goes to bits [7:0]).
- FSM states: CNT_LO, CNT_HI, DATA, DONE, ERR. Reset state is CNT_LO.
  - CNT_LO: on accept, latch count[7:0] → CNT_HI.
  - CNT_HI: on accept, latch count[15:8].
    - If the full count is 0 or greater than `DEPTH` → ERR.
    - Otherwise → DATA, with word index 0 and byte lane 0.
  - DATA: on accept, store the byte in the assembly register at the current lane, then lane+1.
    - On lane 3, write the assembled word (current byte in [31:24]) to mem[word index], clear lane to 0, and increment word index.
    - If the word index was N−1 → DONE.
  - DONE: `loaded`=1. Holds until `rst`.
  - ERR: `err`=1. Holds until `rst`.
- `in_ready` = 1 in CNT_LO, CNT_HI and DATA; 0 in DONE and ERR.
- Read path (asynchronous):
  - `instr_data` = mem[`instr_addr`[AW-1:0]] only when `loaded`=1 and `instr_addr` < N.
  - In every other case `instr_data` = 32'h00000013 (NOP). This covers not loaded, err, index ≥ N, and any upper address bits set, including 0xFFFFFFFF.
- `last_pc` = N−1 (zero-extended) when `loaded`=1; otherwise 32'hFFFFFFFF.
- Memory contents are not cleared by `rst`. Stale words are never visible, because reads are masked by `loaded` and N.

## Timing
- Reset values: `in_ready`=1, `loaded`=0, `err`=0, `last_pc`=0xFFFFFFFF, `instr_data`=0x13. Internal: N=0, word index=0, lane=0.
- One byte is accepted per cycle at most. With `in_valid` held high, a full load takes 2+4N cycles.
- The edge that accepts the final byte also:
  - writes the last word,
  - sets `loaded`,
  - moves `last_pc` to N−1.
  
  The last word is readable combinationally in the cycle after that edge.
- Write/read collision: none is possible, because reads are masked until `loaded`.
- `rst` has priority over a simultaneous byte accept; that byte is dropped.
- `rst` mid-load (any state): return to CNT_LO with `loaded`=0 and `err`=0. The previous partial load is discarded.
- `in_valid` dropping between bytes stalls the FSM with no state change. The lane and word index are preserved.
- Combinational path `instr_addr` → `instr_data` is required, because the core latches `instr_data` on the same edge that advances its PC.

## Test plan
- Nominal load: with `in_valid` held high, send 02 00 | 93 00 10 00 | 13 01 20 00.
  - `loaded` rises after the 10th accept; `last_pc`=1.
  - `instr_addr`=0 → 0x00100093; `instr_addr`=1 → 0x00200113; `instr_addr`=2 → 0x13.
- Gapped handshake: same stream with `in_valid` toggled every other cycle.
  - Identical memory contents; `loaded` rises only on the 10th accepted byte.
- Header errors:
  - Count 00 00 → `err`=1, `in_ready`=0.
  - Count `DEPTH`+1 → `err`=1, `in_ready`=0.
  - In both cases further bytes are ignored and `last_pc` stays 0xFFFFFFFF.
- Reset mid-load: send the count and 5 data bytes, assert `rst` for 1 cycle, then reload a 1-word program 33 05 00 00.
  - `last_pc`=0; addr 0 → 0x00000533; addr 1 → 0x13.
- Pre-load reads: before `loaded`, sweep `instr_addr` over 0, 5 and 0xFFFFFFFF.
  - Always 0x13; `last_pc`=0xFFFFFFFF.
- Full-depth load: N=`DEPTH` with word i = i.
  - addr `DEPTH`−1 → `DEPTH`−1; `last_pc`=`DEPTH`−1.
  - addr `DEPTH` → 0x13; `in_ready`=0 after completion.
